// File: rtl/drac_pkg.sv
// Shared types for the dcache response path: per-tag load metadata and access size encoding.
package drac_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_t;

  typedef struct packed {
    ld_size_t   size;
    logic       is_unsigned;
    logic [2:0] offset;
    logic       store;
    logic       fp32;
  } dcache_ld_meta_t;

  localparam int DCACHE_TAG_W  = 7;
  localparam int DCACHE_DATA_W = 64;
  localparam int DCACHE_CNT_W  = 8;

  function automatic dcache_ld_meta_t make_ld_meta(input logic [1:0] size, input logic is_unsigned,
                                                   input logic [2:0] offset, input logic store,
                                                   input logic fp32);
    dcache_ld_meta_t m;
    m.size        = ld_size_t'(size);
    m.is_unsigned = is_unsigned;
    m.offset      = offset;
    m.store       = store;
    m.fp32        = fp32;
    return m;
  endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Combinational load formatter: shifts the returned doubleword to the access offset,
// then sign/zero-extends to the access size or NaN-boxes single-precision loads.
module dcache_load_align
  import drac_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw,
  input  dcache_ld_meta_t   meta,
  output logic [DATA_W-1:0] result
);

  logic [2:0]        eff_off;
  logic [DATA_W-1:0] shifted;
  logic              sext;

  always_comb begin
    eff_off = 3'd0;
    case (meta.size)
      LD_B:    eff_off = meta.offset;
      LD_H:    eff_off = {meta.offset[2:1], 1'b0};
      LD_W:    eff_off = {meta.offset[2], 2'b00};
      default: eff_off = 3'd0;
    endcase
  end

  assign shifted = raw >> {eff_off, 3'b000};
  assign sext    = ~meta.is_unsigned;

  always_comb begin
    result = shifted;
    case (meta.size)
      LD_B:    result = {{(DATA_W-8){sext & shifted[7]}}, shifted[7:0]};
      LD_H:    result = {{(DATA_W-16){sext & shifted[15]}}, shifted[15:0]};
      LD_W:    result = {{(DATA_W-32){sext & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
    // single-precision values live NaN-boxed in the 64-bit FP register file
    if (meta.fp32) begin
      result = {{(DATA_W-32){1'b1}}, shifted[31:0]};
    end
  end

endmodule

// File: rtl/dcache_rsp_formatter.sv
// Tracks metadata of accepted dcache requests by tag and turns each response into one
// registered, writeback-ready result; counts outstanding requests and flags protocol errors.
module dcache_rsp_formatter
  import drac_pkg::*;
#(
  parameter int TAG_W  = DCACHE_TAG_W,
  parameter int DATA_W = DCACHE_DATA_W,
  parameter int CNT_W  = DCACHE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_fire_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [2:0]        req_offset_i,
  input  logic              req_is_store_i,
  input  logic              req_is_fp32_i,
  input  logic              flush_i,
  input  logic              rsp_valid_i,
  input  logic [TAG_W-1:0]  rsp_tag_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              out_valid_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_is_store_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              err_o
);

  localparam int DEPTH = 2 ** TAG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] killed_q;
  dcache_ld_meta_t  meta_q [DEPTH];

  dcache_ld_meta_t   req_meta;
  dcache_ld_meta_t   rsp_meta;
  logic [DATA_W-1:0] aligned;
  logic              rsp_hit;
  logic              rsp_deliver;
  logic              rsp_orphan;
  logic              req_dup;
  logic              cnt_inc;
  logic              cnt_dec;

  assign req_meta    = make_ld_meta(req_size_i, req_unsigned_i, req_offset_i,
                                    req_is_store_i, req_is_fp32_i);
  assign rsp_meta    = meta_q[rsp_tag_i];
  assign rsp_hit     = rsp_valid_i & valid_q[rsp_tag_i];
  assign rsp_deliver = rsp_hit & ~killed_q[rsp_tag_i];
  assign rsp_orphan  = rsp_valid_i & ~valid_q[rsp_tag_i];
  // a tag retired by a response in the same cycle may be legally reissued
  assign req_dup     = req_fire_i & valid_q[req_tag_i] &
                       ~(rsp_valid_i & (rsp_tag_i == req_tag_i));
  assign cnt_inc     = req_fire_i & ~req_dup;
  assign cnt_dec     = rsp_hit;

  dcache_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .raw    (rsp_data_i),
    .meta   (rsp_meta),
    .result (aligned)
  );

  // later assignments win: flush, then response retire, then new request
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q  <= '0;
      killed_q <= '0;
    end else begin
      if (flush_i) begin
        killed_q <= killed_q | valid_q;
      end
      if (rsp_valid_i) begin
        valid_q[rsp_tag_i]  <= 1'b0;
        killed_q[rsp_tag_i] <= 1'b0;
      end
      if (req_fire_i) begin
        valid_q[req_tag_i]  <= 1'b1;
        killed_q[req_tag_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_fire_i) begin
      meta_q[req_tag_i] <= req_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o    <= 1'b0;
      out_tag_o      <= '0;
      out_data_o     <= '0;
      out_is_store_o <= 1'b0;
    end else begin
      out_valid_o <= rsp_deliver;
      if (rsp_deliver) begin
        out_tag_o      <= rsp_tag_i;
        out_data_o     <= rsp_meta.store ? '0 : aligned;
        out_is_store_o <= rsp_meta.store;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (cnt_inc && !cnt_dec && inflight_o != CNT_MAX) begin
        inflight_o <= inflight_o + 1'b1;
      end else if (cnt_dec && !cnt_inc && inflight_o != '0) begin
        inflight_o <= inflight_o - 1'b1;
      end
      if (rsp_orphan || req_dup) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
